dac_start_sequencer: RTL and testbench

Sequences DAC bring-up from the software-written `startDAC` control word. It sits in the `user_clk` domain between the `user_data_out` of the `opb_register_ppc2simulink` startDAC register and the DAC interface pins. The block drives DAC reset, waits for the DAC clock to lock, waits out a settle interval, issues a one-cycle sync, and then holds the DAC enabled. It also returns a status word for a simulink2ppc readback register.

---
 rtl/dac_start_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dac_start_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_start_sequencer.sv
// DAC bring-up sequencer: reset pulse, lock wait, settle, sync, run.
// Lives entirely in user_clk; dac_locked is resynchronised on entry.
module dac_start_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] cmd_word,
  input  logic        dac_locked,
  output logic        dac_rst,
  output logic        dac_sync,
  output logic        dac_en,
  output logic [31:0] status
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_SETTLE    = 3'd3,
    S_SYNC      = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam logic [19:0] C_RST_LOAD  = 20'(RST_CYCLES - 1);
  localparam logic [19:0] C_LOCK_LOAD = 20'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] F_NONE     = 2'b00;
  localparam logic [1:0] F_TIMEOUT  = 2'b01;
  localparam logic [1:0] F_LOCKLOSS = 2'b10;

  state_t      r_state;
  state_t      w_nxt;
  logic [19:0] r_cnt;
  logic [19:0] w_cnt_nxt;
  logic [1:0]  r_fault;
  logic [1:0]  w_fault_nxt;
  logic [7:0]  r_start_cnt;
  logic        r_lock_m;
  logic        r_lock_s;
  logic [1:0]  r_cmd_q;
  logic        r_dac_rst;
  logic        r_dac_sync;
  logic        r_dac_en;
  logic        w_start_e;
  logic        w_stop_e;
  logic        w_sync_done;
  logic        w_cnt_zero;
  logic        w_unused;

  // Command bits outside start/stop/settle carry no meaning here.
  assign w_unused = ^{cmd_word[31:24], cmd_word[7:2]};

  assign w_start_e   = cmd_word[0] & ~r_cmd_q[0];
  assign w_stop_e    = cmd_word[1] & ~r_cmd_q[1];
  assign w_cnt_zero  = (r_cnt == 20'd0);
  assign w_sync_done = (r_state == S_SYNC) && (w_nxt == S_RUN);

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_lock_m <= dac_locked;
      r_lock_s <= r_lock_m;
    end
  end

  // Previous start/stop levels, so only rising edges act as commands.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_cmd_q <= 2'b00;
    end else begin
      r_cmd_q <= cmd_word[1:0];
    end
  end

  // Next-state, counter and fault decode; a stop edge beats everything.
  always_comb begin
    w_nxt       = r_state;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
    if (w_stop_e) begin
      w_nxt       = S_IDLE;
      w_fault_nxt = F_NONE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start_e) begin
            w_nxt     = S_RESET;
            w_cnt_nxt = C_RST_LOAD;
          end
        end
        S_RESET: begin
          if (w_cnt_zero) begin
            w_nxt     = S_WAIT_LOCK;
            w_cnt_nxt = C_LOCK_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - 20'd1;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_nxt     = S_SETTLE;
            w_cnt_nxt = {4'h0, cmd_word[23:8]};
          end else if (w_cnt_zero) begin
            w_nxt       = S_FAULT;
            w_fault_nxt = F_TIMEOUT;
          end else begin
            w_cnt_nxt = r_cnt - 20'd1;
          end
        end
        S_SETTLE: begin
          if (!r_lock_s) begin
            w_nxt       = S_FAULT;
            w_fault_nxt = F_LOCKLOSS;
          end else if (w_cnt_zero) begin
            w_nxt = S_SYNC;
          end else begin
            w_cnt_nxt = r_cnt - 20'd1;
          end
        end
        S_SYNC: begin
          w_nxt = S_RUN;
        end
        S_RUN: begin
          if (!r_lock_s) begin
            w_nxt       = S_FAULT;
            w_fault_nxt = F_LOCKLOSS;
          end
        end
        S_FAULT: begin
          w_nxt = S_FAULT;
        end
        default: begin
          w_nxt       = S_IDLE;
          w_fault_nxt = F_NONE;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 20'd0;
      r_fault    <= F_NONE;
      r_dac_rst  <= 1'b0;
      r_dac_sync <= 1'b0;
      r_dac_en   <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fault    <= w_fault_nxt;
      r_dac_rst  <= (w_nxt == S_RESET);
      r_dac_sync <= (w_nxt == S_SYNC);
      r_dac_en   <= (w_nxt == S_RUN);
    end
  end

  // Count completed bring-ups; wraps naturally at 8 bits.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_start_cnt <= 8'd0;
    end else if (w_sync_done) begin
      r_start_cnt <= r_start_cnt + 8'd1;
    end
  end

  assign dac_rst  = r_dac_rst;
  assign dac_sync = r_dac_sync;
  assign dac_en   = r_dac_en;
  assign status   = {16'h0000, r_start_cnt, 3'b000, r_fault, r_state};

endmodule

// File: tb/tb_dac_start_sequencer.sv
// Bench for dac_start_sequencer: vector table, corner sequences,
// and random traffic against a cycle-level behavioural model.
module tb_dac_start_sequencer;

  localparam int TB_RST = 16;
  localparam int TB_LT  = 100;

  localparam int P_IDLE  = 0;
  localparam int P_RESET = 1;
  localparam int P_WAIT  = 2;
  localparam int P_SETL  = 3;
  localparam int P_SYNC  = 4;
  localparam int P_RUN   = 5;
  localparam int P_FAULT = 6;

  logic        clk;
  logic        user_rst;
  logic [31:0] cmd_word;
  logic        dac_locked;
  logic        dac_rst;
  logic        dac_sync;
  logic        dac_en;
  logic [31:0] status;

  int n_checks;
  int n_err;

  dac_start_sequencer #(
    .RST_CYCLES  (TB_RST),
    .LOCK_TIMEOUT(TB_LT)
  ) dut (
    .user_clk  (clk),
    .user_rst  (user_rst),
    .cmd_word  (cmd_word),
    .dac_locked(dac_locked),
    .dac_rst   (dac_rst),
    .dac_sync  (dac_sync),
    .dac_en    (dac_en),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] cmd;
    logic        lock;
    int          n;
    logic [31:0] st;
    logic [2:0]  o;
  } vec_t;

  // Behavioural model state
  int   m_ph;
  int   m_n;
  int   m_tgt;
  int   m_sc;
  int   m_fault;
  logic [1:0] m_pc;
  logic m_pipe[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic lk);
    user_rst   = 1'b1;
    cmd_word   = 32'h0;
    dac_locked = lk;
    tick();
    tick();
    user_rst = 1'b0;
  endtask

  task automatic model_reset();
    m_ph    = P_IDLE;
    m_n     = 0;
    m_tgt   = 0;
    m_sc    = 0;
    m_fault = 0;
    m_pc    = 2'b00;
    m_pipe  = {1'b0, 1'b0};
  endtask

  // One clock edge of the model, given inputs held before that edge.
  task automatic model_step(input logic [31:0] c, input logic l);
    logic ls;
    logic st_e;
    logic sp_e;
    ls = m_pipe[0];
    void'(m_pipe.pop_front());
    m_pipe.push_back(l);
    st_e = c[0] & ~m_pc[0];
    sp_e = c[1] & ~m_pc[1];
    m_pc = c[1:0];
    if (sp_e) begin
      m_ph    = P_IDLE;
      m_fault = 0;
    end else if (m_ph == P_IDLE) begin
      if (st_e) begin
        m_ph = P_RESET;
        m_n  = 0;
      end
    end else if (m_ph == P_RESET) begin
      if (m_n == TB_RST - 1) begin
        m_ph = P_WAIT;
        m_n  = 0;
      end else m_n++;
    end else if (m_ph == P_WAIT) begin
      if (ls) begin
        m_ph  = P_SETL;
        m_n   = 0;
        m_tgt = int'(c[23:8]);
      end else if (m_n == TB_LT - 1) begin
        m_ph    = P_FAULT;
        m_fault = 1;
      end else m_n++;
    end else if (m_ph == P_SETL) begin
      if (!ls) begin
        m_ph    = P_FAULT;
        m_fault = 2;
      end else if (m_n == m_tgt) m_ph = P_SYNC;
      else m_n++;
    end else if (m_ph == P_SYNC) begin
      m_ph = P_RUN;
      m_sc = (m_sc + 1) % 256;
    end else if (m_ph == P_RUN) begin
      if (!ls) begin
        m_ph    = P_FAULT;
        m_fault = 2;
      end
    end
  endtask

  function automatic logic [34:0] model_out();
    logic [7:0] sc;
    logic [1:0] f;
    logic [2:0] p;
    sc = 8'(m_sc);
    f  = 2'(m_fault);
    p  = 3'(m_ph);
    return {m_ph == P_RESET, m_ph == P_SYNC, m_ph == P_RUN,
            16'h0, sc, 3'b000, f, p};
  endfunction

  vec_t vt[20];

  initial begin
    int n;
    n_checks   = 0;
    n_err      = 0;
    user_rst   = 1'b1;
    cmd_word   = 32'h0;
    dac_locked = 1'b0;

    // Nominal start, lock loss, stop, simultaneous start+stop
    vt[0]  = '{32'h400, 1'b1, 3,  32'h000, 3'b000};
    vt[1]  = '{32'h401, 1'b1, 1,  32'h001, 3'b100};
    vt[2]  = '{32'h401, 1'b1, 15, 32'h001, 3'b100};
    vt[3]  = '{32'h401, 1'b1, 1,  32'h002, 3'b000};
    vt[4]  = '{32'h401, 1'b1, 1,  32'h003, 3'b000};
    vt[5]  = '{32'h401, 1'b1, 4,  32'h003, 3'b000};
    vt[6]  = '{32'h401, 1'b1, 1,  32'h004, 3'b010};
    vt[7]  = '{32'h401, 1'b1, 1,  32'h105, 3'b001};
    vt[8]  = '{32'h401, 1'b1, 5,  32'h105, 3'b001};
    vt[9]  = '{32'h402, 1'b1, 1,  32'h100, 3'b000};
    vt[10] = '{32'h403, 1'b1, 1,  32'h101, 3'b100};
    vt[11] = '{32'h400, 1'b1, 21, 32'h103, 3'b000};
    vt[12] = '{32'h400, 1'b1, 2,  32'h205, 3'b001};
    vt[13] = '{32'h400, 1'b0, 2,  32'h205, 3'b001};
    vt[14] = '{32'h400, 1'b0, 1,  32'h216, 3'b000};
    vt[15] = '{32'h400, 1'b0, 4,  32'h216, 3'b000};
    vt[16] = '{32'h402, 1'b1, 1,  32'h200, 3'b000};
    vt[17] = '{32'h400, 1'b1, 1,  32'h200, 3'b000};
    vt[18] = '{32'h403, 1'b1, 1,  32'h200, 3'b000};
    vt[19] = '{32'h403, 1'b1, 3,  32'h200, 3'b000};

    tick();
    check("reset_status", {29'h0, dac_rst, dac_sync, dac_en, status},
          64'h0);
    user_rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cmd_word   = vt[i].cmd;
      dac_locked = vt[i].lock;
      repeat (vt[i].n) tick();
      check($sformatf("vec%0d", i),
            {29'h0, dac_rst, dac_sync, dac_en, status},
            {29'h0, vt[i].o, vt[i].st});
    end

    // Lock timeout
    do_reset(1'b0);
    cmd_word = 32'h1;
    tick();
    n = 0;
    while (dac_rst && n < 100) begin
      n++;
      tick();
    end
    check("rst_width", 64'(n), 64'(TB_RST));
    n = 0;
    while (status[2:0] != 3'd6 && n < 300) begin
      tick();
      n++;
    end
    check("timeout_len", 64'(n), 64'(TB_LT));
    check("timeout_status", 64'(status), 64'h0E);
    cmd_word = 32'h0;
    tick();
    cmd_word = 32'h1;
    repeat (3) tick();
    check("fault_ignore_start", {63'h0, dac_rst} | 64'(status) << 1,
          64'h0E << 1);
    cmd_word = 32'h3;
    tick();
    check("fault_stop", 64'(status[4:0]), 64'h0);

    // Stop alone mid-SETTLE
    do_reset(1'b1);
    cmd_word = 32'h0001_0001;
    n = 0;
    while (status[2:0] != 3'd3 && n < 40) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check("in_settle", 64'(status[2:0]), 64'd3);
    cmd_word = 32'h0001_0003;
    tick();
    check("settle_stop", {61'h0, dac_rst, dac_sync, dac_en} |
          64'(status[2:0]) << 3, 64'h0);

    // start_count wrap
    do_reset(1'b1);
    tick();
    for (int i = 0; i < 256; i++) begin
      cmd_word = 32'h1;
      n = 0;
      while (!dac_en && n < 50) begin
        tick();
        n++;
      end
      check("wrap_en", 64'(dac_en), 64'd1);
      if (i == 0) check("cnt_first", 64'(status[15:8]), 64'h01);
      if (i == 254) check("cnt_ff", 64'(status[15:8]), 64'hFF);
      if (i == 255) check("cnt_wrap", 64'(status[15:8]), 64'h00);
      cmd_word = 32'h2;
      tick();
      cmd_word = 32'h0;
      tick();
    end
    cmd_word = 32'h1;
    n = 0;
    while (!dac_en && n < 50) begin
      tick();
      n++;
    end
    cmd_word = 32'h3;
    tick();
    repeat (30) tick();
    check("held_level", 64'(status), 64'h100);

    // Async reset mid-WAIT_LOCK
    do_reset(1'b0);
    cmd_word = 32'h400;
    tick();
    cmd_word = 32'h401;
    n = 0;
    while (status[2:0] != 3'd2 && n < 40) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("pre_async", 64'(status[2:0]), 64'd2);
    #3;
    user_rst = 1'b1;
    #1;
    check("async_rst", {29'h0, dac_rst, dac_sync, dac_en, status},
          64'h0);
    cmd_word   = 32'h0;
    dac_locked = 1'b1;
    #2;
    user_rst = 1'b0;
    tick();
    tick();
    check("post_rst_idle", 64'(status), 64'h0);
    cmd_word = 32'h1;
    n = 0;
    while (!dac_en && n < 50) begin
      tick();
      n++;
    end
    check("restart", 64'(status), 64'h105);

    // Random traffic vs model
    do_reset(1'b1);
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) cmd_word[0] = ~cmd_word[0];
      if ($urandom_range(0, 39) == 0) cmd_word[1] = ~cmd_word[1];
      if ($urandom_range(0, 15) == 0)
        cmd_word[23:8] = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0)
        cmd_word[31:24] = 8'($urandom);
      if (dac_locked && $urandom_range(0, 59) == 0) dac_locked = 1'b0;
      else if (!dac_locked && $urandom_range(0, 7) == 0)
        dac_locked = 1'b1;
      @(posedge clk);
      model_step(cmd_word, dac_locked);
      #1;
      check($sformatf("rand%0d", i),
            {29'h0, dac_rst, dac_sync, dac_en, status},
            {29'h0, model_out()});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
